// File: rtl/alu_pkg.sv
// alu_pkg: ALU control encodings shared by the decode stage and the ALU,
// RV opcode/funct constants, the immediate format select and the decoded
// control bundle.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD_SUB = 3'd0,
    ALU_XOR     = 3'd1,
    ALU_OR      = 3'd2,
    ALU_AND     = 3'd3,
    ALU_SLL     = 3'd4,
    ALU_SRL_SRA = 3'd5,
    ALU_SLT     = 3'd6,
    ALU_SLTU    = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    SRC1_REG  = 2'd0,
    SRC1_PC   = 2'd1,
    SRC1_ZERO = 2'd2
  } alu_src1_t;

  typedef enum logic [1:0] {
    SRC2_REG  = 2'd0,
    SRC2_IMM  = 2'd1,
    SRC2_FOUR = 2'd2
  } alu_src2_t;

  // Immediate formats understood by imm_gen; SHAMT is instr[25:20] zero-extended.
  typedef enum logic [2:0] {
    IMM_NONE  = 3'd0,
    IMM_I     = 3'd1,
    IMM_S     = 3'd2,
    IMM_B     = 3'd3,
    IMM_U     = 3'd4,
    IMM_J     = 3'd5,
    IMM_SHAMT = 3'd6
  } imm_fmt_t;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Decoded control bundle (immediate and PC are carried separately).
  typedef struct packed {
    alu_op_t   alu_op;
    logic      sub_sra;
    alu_src1_t src1;
    alu_src2_t src2;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic      rd_write;
    logic      mem_read;
    logic      mem_write;
    logic      branch;
    logic      branch_invert;
    logic      jump;
    logic      illegal;
  } dec_t;

  // funct3 of OP / OP-IMM maps one-to-one onto an ALU operation.
  function automatic alu_op_t f3_to_op(input logic [2:0] f3);
    alu_op_t op;
    case (f3)
      F3_ADD:  op = ALU_ADD_SUB;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SRL:  op = ALU_SRL_SRA;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational immediate extraction. The opcode bits carry no
// immediate information, so only instr[31:7] is taken.
module imm_gen
  import alu_pkg::*;
(
  input  logic [31:7] i_instr,
  input  imm_fmt_t    i_fmt,
  output logic [63:0] o_imm
);

  // Assemble and sign-extend the immediate for the selected format.
  always_comb begin
    o_imm = '0;
    case (i_fmt)
      IMM_I:     o_imm = {{52{i_instr[31]}}, i_instr[31:20]};
      IMM_S:     o_imm = {{52{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B:     o_imm = {{51{i_instr[31]}}, i_instr[31], i_instr[7],
                          i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_U:     o_imm = {{32{i_instr[31]}}, i_instr[31:12], 12'b0};
      IMM_J:     o_imm = {{43{i_instr[31]}}, i_instr[31], i_instr[19:12],
                          i_instr[20], i_instr[30:21], 1'b0};
      IMM_SHAMT: o_imm = {58'b0, i_instr[25:20]};
      default:   o_imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV64I decoder between fetch and execute.
// Single-entry output register with valid/ready on both sides; flush drops
// the held bundle and swallows any instruction offered in the same cycle.
// Optional build macro DECODE_STAGE_WORD_OPS_EN adds OP-32 / OP-IMM-32
// decoding and the word_out port; without it those opcodes are illegal.
module decode_stage
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_in,
  input  logic        in_valid_in,
  output logic        in_ready_out,
  input  logic [31:0] instr_in,
  input  logic [63:0] pc_in,
  output logic        out_valid_out,
  input  logic        out_ready_in,
  output logic [63:0] pc_out,
  output alu_op_t     alu_op_out,
  output logic        sub_sra_out,
  output alu_src1_t   src1_out,
  output alu_src2_t   src2_out,
  output logic [63:0] imm_out,
  output logic [4:0]  rs1_out,
  output logic [4:0]  rs2_out,
  output logic [4:0]  rd_out,
  output logic        rd_write_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic        branch_out,
  output logic        branch_invert_out,
  output logic        jump_out,
`ifdef DECODE_STAGE_WORD_OPS_EN
  output logic        word_out,
`endif
  output logic        illegal_out
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic        w_accept;
  logic        w_ill;
  logic        w_writes;
  logic        w_word;
  imm_fmt_t    w_fmt;
  dec_t        w_dec;
  logic [63:0] w_imm;

  logic        r_valid;
  dec_t        r_dec;
  logic [63:0] r_imm;
  logic [63:0] r_pc;
  logic        r_word;

  assign w_opcode = instr_in[6:0];
  assign w_funct3 = instr_in[14:12];
  assign w_funct7 = instr_in[31:25];

  // Flush forces ready so a concurrent instruction is consumed and dropped.
  assign in_ready_out = !r_valid || out_ready_in || flush_in;
  assign w_accept     = in_valid_in && in_ready_out;

  imm_gen u_imm_gen (
    .i_instr (instr_in[31:7]),
    .i_fmt   (w_fmt),
    .o_imm   (w_imm)
  );

  // Decode the incoming word; any illegal encoding collapses to the neutral bundle.
  always_comb begin
    w_dec     = '0;
    w_dec.rs1 = instr_in[19:15];
    w_dec.rs2 = instr_in[24:20];
    w_dec.rd  = instr_in[11:7];
    w_fmt     = IMM_NONE;
    w_ill     = 1'b0;
    w_writes  = 1'b0;
    w_word    = 1'b0;
    case (w_opcode)
      OPC_LUI: begin
        w_dec.src1 = SRC1_ZERO;
        w_dec.src2 = SRC2_IMM;
        w_fmt      = IMM_U;
        w_writes   = 1'b1;
      end
      OPC_AUIPC: begin
        w_dec.src1 = SRC1_PC;
        w_dec.src2 = SRC2_IMM;
        w_fmt      = IMM_U;
        w_writes   = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        w_dec.src1 = SRC1_PC;
        w_dec.src2 = SRC2_FOUR;
        w_dec.jump = 1'b1;
        w_fmt      = (w_opcode == OPC_JAL) ? IMM_J : IMM_I;
        w_writes   = 1'b1;
      end
      OPC_LOAD: begin
        w_dec.src2     = SRC2_IMM;
        w_dec.mem_read = 1'b1;
        w_fmt          = IMM_I;
        w_writes       = 1'b1;
      end
      OPC_STORE: begin
        w_dec.src2      = SRC2_IMM;
        w_dec.mem_write = 1'b1;
        w_fmt           = IMM_S;
      end
      OPC_BRANCH: begin
        w_dec.branch = 1'b1;
        w_fmt        = IMM_B;
        case (w_funct3)
          F3_BEQ:  begin w_dec.sub_sra = 1'b1; w_dec.branch_invert = 1'b1; end
          F3_BNE:  w_dec.sub_sra = 1'b1;
          F3_BLT:  w_dec.alu_op = ALU_SLT;
          F3_BGE:  begin w_dec.alu_op = ALU_SLT; w_dec.branch_invert = 1'b1; end
          F3_BLTU: w_dec.alu_op = ALU_SLTU;
          F3_BGEU: begin w_dec.alu_op = ALU_SLTU; w_dec.branch_invert = 1'b1; end
          default: w_ill = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        w_dec.alu_op = f3_to_op(w_funct3);
        w_dec.src2   = SRC2_IMM;
        w_fmt        = IMM_I;
        w_writes     = 1'b1;
        if (w_funct3 == F3_SLL) begin
          w_fmt = IMM_SHAMT;
          w_ill = (instr_in[31:26] != 6'b000000);
        end else if (w_funct3 == F3_SRL) begin
          w_fmt         = IMM_SHAMT;
          w_dec.sub_sra = instr_in[30];
          w_ill         = (instr_in[31:26] != 6'b000000) && (instr_in[31:26] != 6'b010000);
        end
      end
      OPC_OP: begin
        w_dec.alu_op = f3_to_op(w_funct3);
        w_writes     = 1'b1;
        if ((w_funct3 == F3_ADD) || (w_funct3 == F3_SRL)) begin
          w_dec.sub_sra = instr_in[30];
          w_ill         = (w_funct7 != F7_BASE) && (w_funct7 != F7_ALT);
        end else begin
          w_ill = (w_funct7 != F7_BASE);
        end
      end
`ifdef DECODE_STAGE_WORD_OPS_EN
      // Only ADD/SLL/SRL(A) exist in word form; funct7 check also pins instr[25]=0 for shifts.
      OPC_OP_IMM_32: begin
        w_dec.alu_op = f3_to_op(w_funct3);
        w_dec.src2   = SRC2_IMM;
        w_writes     = 1'b1;
        w_word       = 1'b1;
        case (w_funct3)
          F3_ADD: w_fmt = IMM_I;
          F3_SLL: begin
            w_fmt = IMM_SHAMT;
            w_ill = (w_funct7 != F7_BASE);
          end
          F3_SRL: begin
            w_fmt         = IMM_SHAMT;
            w_dec.sub_sra = instr_in[30];
            w_ill         = (w_funct7 != F7_BASE) && (w_funct7 != F7_ALT);
          end
          default: w_ill = 1'b1;
        endcase
      end
      OPC_OP_32: begin
        w_dec.alu_op = f3_to_op(w_funct3);
        w_writes     = 1'b1;
        w_word       = 1'b1;
        case (w_funct3)
          F3_ADD, F3_SRL: begin
            w_dec.sub_sra = instr_in[30];
            w_ill         = (w_funct7 != F7_BASE) && (w_funct7 != F7_ALT);
          end
          F3_SLL:  w_ill = (w_funct7 != F7_BASE);
          default: w_ill = 1'b1;
        endcase
      end
`endif
      default: w_ill = 1'b1;
    endcase

    w_dec.rd_write = w_writes && (w_dec.rd != 5'd0);

    if (w_ill) begin
      w_dec         = '0;
      w_dec.rs1     = instr_in[19:15];
      w_dec.rs2     = instr_in[24:20];
      w_dec.rd      = instr_in[11:7];
      w_dec.illegal = 1'b1;
      w_fmt         = IMM_NONE;
      w_word        = 1'b0;
    end
  end

  // Output register: flush beats accept, accept beats drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_dec   <= '0;
      r_imm   <= '0;
      r_pc    <= '0;
      r_word  <= 1'b0;
    end else if (flush_in) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_dec   <= w_dec;
      r_imm   <= w_imm;
      r_pc    <= pc_in;
      r_word  <= w_word;
    end else if (out_ready_in) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid_out     = r_valid;
  assign pc_out            = r_pc;
  assign alu_op_out        = r_dec.alu_op;
  assign sub_sra_out       = r_dec.sub_sra;
  assign src1_out          = r_dec.src1;
  assign src2_out          = r_dec.src2;
  assign imm_out           = r_imm;
  assign rs1_out           = r_dec.rs1;
  assign rs2_out           = r_dec.rs2;
  assign rd_out            = r_dec.rd;
  assign rd_write_out      = r_dec.rd_write;
  assign mem_read_out      = r_dec.mem_read;
  assign mem_write_out     = r_dec.mem_write;
  assign branch_out        = r_dec.branch;
  assign branch_invert_out = r_dec.branch_invert;
  assign jump_out          = r_dec.jump;
  assign illegal_out       = r_dec.illegal;
`ifdef DECODE_STAGE_WORD_OPS_EN
  assign word_out          = r_word;
`else
  logic w_word_unused;
  assign w_word_unused = r_word;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors with hand-computed expectations for decode_stage.
module tb_decode_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_in;
  logic        in_valid_in;
  logic        in_ready_out;
  logic [31:0] instr_in;
  logic [63:0] pc_in;
  logic        out_valid_out;
  logic        out_ready_in;
  logic [63:0] pc_out;
  alu_op_t     alu_op_out;
  logic        sub_sra_out;
  alu_src1_t   src1_out;
  alu_src2_t   src2_out;
  logic [63:0] imm_out;
  logic [4:0]  rs1_out, rs2_out, rd_out;
  logic        rd_write_out, mem_read_out, mem_write_out;
  logic        branch_out, branch_invert_out, jump_out, illegal_out;
`ifdef DECODE_STAGE_WORD_OPS_EN
  logic        word_out;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk               (clk),
    .reset             (reset),
    .flush_in          (flush_in),
    .in_valid_in       (in_valid_in),
    .in_ready_out      (in_ready_out),
    .instr_in          (instr_in),
    .pc_in             (pc_in),
    .out_valid_out     (out_valid_out),
    .out_ready_in      (out_ready_in),
    .pc_out            (pc_out),
    .alu_op_out        (alu_op_out),
    .sub_sra_out       (sub_sra_out),
    .src1_out          (src1_out),
    .src2_out          (src2_out),
    .imm_out           (imm_out),
    .rs1_out           (rs1_out),
    .rs2_out           (rs2_out),
    .rd_out            (rd_out),
    .rd_write_out      (rd_write_out),
    .mem_read_out      (mem_read_out),
    .mem_write_out     (mem_write_out),
    .branch_out        (branch_out),
    .branch_invert_out (branch_invert_out),
    .jump_out          (jump_out),
`ifdef DECODE_STAGE_WORD_OPS_EN
    .word_out          (word_out),
`endif
    .illegal_out       (illegal_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [63:0] pc);
    in_valid_in = 1'b1;
    instr_in    = instr;
    pc_in       = pc;
  endtask

  initial begin
    reset = 1'b1; flush_in = 1'b0; in_valid_in = 1'b0;
    instr_in = '0; pc_in = '0; out_ready_in = 1'b1;
    step(); step();
    chk("rst_valid", out_valid_out, 0);
    chk("rst_imm", imm_out, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_rdw", rd_write_out, 0);
    chk("rst_ill", illegal_out, 0);
    reset = 1'b0;
    #1;
    chk("rst_ready", in_ready_out, 1);

    // ADDI x1,x2,-5
    offer(32'hFFB10093, 64'h1000);
    step();
    in_valid_in = 1'b0;
    chk("addi_valid", out_valid_out, 1);
    chk("addi_op", alu_op_out, 0);
    chk("addi_sub", sub_sra_out, 0);
    chk("addi_src1", src1_out, 0);
    chk("addi_src2", src2_out, 1);
    chk("addi_imm", imm_out, 64'hFFFF_FFFF_FFFF_FFFB);
    chk("addi_rd", rd_out, 1);
    chk("addi_rs1", rs1_out, 2);
    chk("addi_rdw", rd_write_out, 1);
    chk("addi_pc", pc_out, 64'h1000);
    step();
    chk("drain_valid", out_valid_out, 0);

    // SRAI x3,x3,63 then the illegal funct6 variant back-to-back
    offer(32'h43F1D193, 64'h1004);
    step();
    chk("srai_op", alu_op_out, 5);
    chk("srai_sra", sub_sra_out, 1);
    chk("srai_imm", imm_out, 63);
    chk("srai_ill", illegal_out, 0);
    offer(32'h83F1D193, 64'h1008);
    step();
    chk("srai_bad_valid", out_valid_out, 1);
    chk("srai_bad_ill", illegal_out, 1);
    chk("srai_bad_rdw", rd_write_out, 0);
    chk("srai_bad_src2", src2_out, 0);
    chk("srai_bad_imm", imm_out, 0);
    chk("srai_bad_pc", pc_out, 64'h1008);

    // BGEU x1,x2,-4
    offer(32'hFE20FEE3, 64'h1010);
    step();
    chk("bgeu_op", alu_op_out, 7);
    chk("bgeu_br", branch_out, 1);
    chk("bgeu_inv", branch_invert_out, 1);
    chk("bgeu_imm", imm_out, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("bgeu_rdw", rd_write_out, 0);
    chk("bgeu_rs2", rs2_out, 2);

    // LUI x5,0x80000 (sign-extended U immediate)
    offer(32'h800002B7, 64'h1014);
    step();
    chk("lui_src1", src1_out, 2);
    chk("lui_src2", src2_out, 1);
    chk("lui_imm", imm_out, 64'hFFFF_FFFF_8000_0000);
    chk("lui_rdw", rd_write_out, 1);

    // SUB x3,x1,x2 then AND with funct7=0100000 (illegal)
    offer(32'h402081B3, 64'h1018);
    step();
    chk("sub_op", alu_op_out, 0);
    chk("sub_sub", sub_sra_out, 1);
    chk("sub_src2", src2_out, 0);
    chk("sub_ill", illegal_out, 0);
    offer(32'h4020F1B3, 64'h101C);
    step();
    chk("and_alt_ill", illegal_out, 1);
    chk("and_alt_op", alu_op_out, 0);

    // ADDW x1,x1,x2: word op with the macro, illegal without
    offer(32'h002080BB, 64'h1020);
    step();
    in_valid_in = 1'b0;
`ifdef DECODE_STAGE_WORD_OPS_EN
    chk("addw_word", word_out, 1);
    chk("addw_ill", illegal_out, 0);
    chk("addw_rdw", rd_write_out, 1);
`else
    chk("addw_ill", illegal_out, 1);
    chk("addw_rdw", rd_write_out, 0);
`endif
    step();

    // JAL x1,+8 held with out_ready low for three cycles
    out_ready_in = 1'b0;
    offer(32'h008000EF, 64'h2000);
    step();
    chk("jal_valid", out_valid_out, 1);
    chk("jal_jump", jump_out, 1);
    chk("jal_src1", src1_out, 1);
    chk("jal_src2", src2_out, 2);
    chk("jal_imm", imm_out, 8);
    offer(32'hFFB10093, 64'h3000);
    for (int i = 0; i < 3; i++) begin
      chk("hold_ready", in_ready_out, 0);
      chk("hold_valid", out_valid_out, 1);
      chk("hold_pc", pc_out, 64'h2000);
      chk("hold_imm", imm_out, 8);
      chk("hold_jump", jump_out, 1);
      step();
    end
    out_ready_in = 1'b1;
    #1;
    chk("release_ready", in_ready_out, 1);
    step();
    in_valid_in = 1'b0;
    chk("next_valid", out_valid_out, 1);
    chk("next_pc", pc_out, 64'h3000);
    chk("next_jump", jump_out, 0);
    chk("next_imm", imm_out, 64'hFFFF_FFFF_FFFF_FFFB);
    step();

    // AUIPC held, then flush together with an offered LUI
    out_ready_in = 1'b0;
    offer(32'h00001397, 64'h4000);
    step();
    chk("auipc_src1", src1_out, 1);
    chk("auipc_imm", imm_out, 64'h1000);
    offer(32'h123452B7, 64'h4004);
    flush_in = 1'b1;
    #1;
    chk("flush_ready", in_ready_out, 1);
    step();
    flush_in = 1'b0;
    in_valid_in = 1'b0;
    chk("flush_valid", out_valid_out, 0);
    step();
    chk("flush_no_lui", out_valid_out, 0);
    chk("flush_pc", pc_out, 64'h4000);

    // Reset in the middle of a held transaction
    offer(32'h402081B3, 64'h5000);
    step();
    in_valid_in = 1'b0;
    chk("pre_rst_valid", out_valid_out, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_valid", out_valid_out, 0);
    chk("mid_rst_pc", pc_out, 0);
    chk("mid_rst_rdw", rd_write_out, 0);
    chk("mid_rst_sub", sub_sra_out, 0);
    chk("mid_rst_ready", in_ready_out, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
